// File: rtl/freq_scan_ctrl_pkg.sv
// Shared widths, defaults and scan-controller state encoding for the
// frequency scan controller and its measurement engine.
package freq_scan_ctrl_pkg;

  localparam int FREQ_SCAN_NCH  = 8;
  localparam int FREQ_CNT_NBIT  = 8;
  localparam int FREQ_TO_NBIT   = 12;
  localparam int FREQ_DATA_NBIT = 16;

  typedef enum logic [2:0] {
    FSC_IDLE  = 3'd0,
    FSC_SEL   = 3'd1,
    FSC_START = 3'd2,
    FSC_WAIT  = 3'd3,
    FSC_STORE = 3'd4,
    FSC_DONE  = 3'd5
  } fsc_state_e;

endpackage

// File: rtl/freq_scan_ctrl_freq_m.sv
// Frequency-measurement engine: counts clock cycles spanned by i_cnt rising
// edges of a synchronised input, with a per-run timeout. done is a level.
module freq_m
  import freq_scan_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      i_io,
  input  logic [FREQ_CNT_NBIT-1:0]  i_cnt,
  input  logic [FREQ_TO_NBIT-1:0]   i_timeout,
  output logic [FREQ_DATA_NBIT-1:0] o_freq,
  output logic [FREQ_CNT_NBIT-1:0]  o_cnt,
  output logic                      o_err,
  output logic                      done
);

  logic [2:0]                sync_q;
  logic                      run_q;
  logic                      armed_q;
  logic                      done_q;
  logic                      err_q;
  logic [FREQ_DATA_NBIT-1:0] freq_q;
  logic [FREQ_CNT_NBIT-1:0]  cnt_q;
  logic [FREQ_TO_NBIT-1:0]   to_q;
  logic                      rise;
  logic [FREQ_CNT_NBIT:0]    cnt_inc;

  assign rise    = sync_q[1] & ~sync_q[2];
  assign cnt_inc = {1'b0, cnt_q} + {{FREQ_CNT_NBIT{1'b0}}, 1'b1};

  // The first edge only arms the cycle counter; later edges are counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      run_q   <= 1'b0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      freq_q  <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
    end else begin
      sync_q <= {sync_q[1:0], i_io};
      if (start) begin
        run_q   <= 1'b1;
        armed_q <= 1'b0;
        done_q  <= 1'b0;
        err_q   <= 1'b0;
        freq_q  <= '0;
        cnt_q   <= '0;
        to_q    <= '0;
      end else if (run_q) begin
        if (to_q >= i_timeout) begin
          err_q  <= 1'b1;
          done_q <= 1'b1;
          run_q  <= 1'b0;
        end else begin
          to_q <= to_q + FREQ_TO_NBIT'(1);
          if (armed_q) freq_q <= freq_q + FREQ_DATA_NBIT'(1);
          if (rise) begin
            if (!armed_q) begin
              armed_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc[FREQ_CNT_NBIT-1:0];
              if (cnt_inc >= {1'b0, i_cnt}) begin
                done_q <= 1'b1;
                run_q  <= 1'b0;
              end
            end
          end
        end
      end
    end
  end

  assign o_freq = freq_q;
  assign o_cnt  = cnt_q;
  assign o_err  = err_q;
  assign done   = done_q;

endmodule

// File: rtl/freq_scan_ctrl.sv
// Multi-channel scan controller: walks the enabled channels lowest-first,
// time-sharing one freq_m engine, and stores a result per channel.
module freq_scan_ctrl
  import freq_scan_ctrl_pkg::*;
#(
  parameter int NCH     = FREQ_SCAN_NCH,
  parameter int CH_NBIT = 3,
  parameter int SETTLE  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NCH-1:0]            i_mask,
  input  logic [FREQ_CNT_NBIT-1:0]  i_cnt,
  input  logic [FREQ_TO_NBIT-1:0]   i_timeout,
  input  logic [NCH-1:0]            i_io,
  input  logic [CH_NBIT-1:0]        i_rd_ch,
  output logic [FREQ_DATA_NBIT-1:0] o_freq,
  output logic [FREQ_CNT_NBIT-1:0]  o_cnt,
  output logic [NCH-1:0]            o_err_mask,
  output logic                      o_busy,
  output logic                      done
);

  localparam int DW = $clog2(SETTLE + 1);

  fsc_state_e                state_q, state_d;
  logic [NCH-1:0]            pend_q, pend_d;
  logic [CH_NBIT-1:0]        ch_q, ch_d;
  logic [DW-1:0]             dwell_q, dwell_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [FREQ_CNT_NBIT-1:0]  cnt_lat_q;
  logic [FREQ_TO_NBIT-1:0]   to_lat_q;
  logic                      eng_done_prev_q;
  logic [FREQ_DATA_NBIT-1:0] freq_q [NCH];
  logic [FREQ_CNT_NBIT-1:0]  cnt_q  [NCH];
  logic [NCH-1:0]            err_q;
  logic [FREQ_DATA_NBIT-1:0] rb_freq_q;
  logic [FREQ_CNT_NBIT-1:0]  rb_cnt_q;

  logic                      eng_start;
  logic                      clr_res;
  logic                      store_res;
  logic [CH_NBIT-1:0]        lsb_idx;
  logic                      io_sel;
  logic [FREQ_DATA_NBIT-1:0] eng_freq;
  logic [FREQ_CNT_NBIT-1:0]  eng_cnt;
  logic                      eng_err;
  logic                      eng_done;

  assign io_sel = i_io[ch_q];

  always_comb begin
    lsb_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i]) lsb_idx = CH_NBIT'(i);
    end
  end

  // SEL spends one cycle picking the channel, then SETTLE cycles of dwell.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    ch_d      = ch_q;
    dwell_d   = dwell_q;
    busy_d    = busy_q;
    done_d    = done_q;
    eng_start = 1'b0;
    clr_res   = 1'b0;
    store_res = 1'b0;
    case (state_q)
      FSC_IDLE: begin
        if (start) begin
          pend_d  = i_mask;
          dwell_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          clr_res = 1'b1;
          state_d = FSC_SEL;
        end
      end
      FSC_SEL: begin
        if (pend_q == '0) begin
          state_d = FSC_DONE;
        end else begin
          if (dwell_q == '0) ch_d = lsb_idx;
          if (dwell_q == DW'(SETTLE)) state_d = FSC_START;
          else dwell_d = dwell_q + DW'(1);
        end
      end
      FSC_START: begin
        eng_start = 1'b1;
        state_d   = FSC_WAIT;
      end
      FSC_WAIT: begin
        if (eng_done && !eng_done_prev_q) state_d = FSC_STORE;
      end
      FSC_STORE: begin
        store_res    = 1'b1;
        pend_d[ch_q] = 1'b0;
        dwell_d      = '0;
        state_d      = FSC_SEL;
      end
      FSC_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = FSC_IDLE;
      end
      default: state_d = FSC_IDLE;
    endcase
    if (abort && state_q != FSC_IDLE) begin
      state_d   = FSC_IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      eng_start = 1'b0;
      store_res = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= FSC_IDLE;
      pend_q          <= '0;
      ch_q            <= '0;
      dwell_q         <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      cnt_lat_q       <= '0;
      to_lat_q        <= '0;
      eng_done_prev_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_q          <= pend_d;
      ch_q            <= ch_d;
      dwell_q         <= dwell_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      eng_done_prev_q <= eng_done;
      if (clr_res) begin
        cnt_lat_q <= i_cnt;
        to_lat_q  <= i_timeout;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        freq_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q     <= '0;
      rb_freq_q <= '0;
      rb_cnt_q  <= '0;
    end else begin
      if (clr_res) begin
        for (int i = 0; i < NCH; i++) begin
          freq_q[i] <= '0;
          cnt_q[i]  <= '0;
        end
        err_q <= '0;
      end else if (store_res) begin
        freq_q[ch_q] <= eng_freq;
        cnt_q[ch_q]  <= eng_cnt;
        err_q[ch_q]  <= eng_err;
      end
      if (int'(i_rd_ch) < NCH) begin
        rb_freq_q <= freq_q[i_rd_ch];
        rb_cnt_q  <= cnt_q[i_rd_ch];
      end else begin
        rb_freq_q <= '0;
        rb_cnt_q  <= '0;
      end
    end
  end

  freq_m u_eng (
    .clk       (clk),
    .rst       (rst),
    .start     (eng_start),
    .i_io      (io_sel),
    .i_cnt     (cnt_lat_q),
    .i_timeout (to_lat_q),
    .o_freq    (eng_freq),
    .o_cnt     (eng_cnt),
    .o_err     (eng_err),
    .done      (eng_done)
  );

  assign o_freq     = rb_freq_q;
  assign o_cnt      = rb_cnt_q;
  assign o_err_mask = err_q;
  assign o_busy     = busy_q;
  assign done       = done_q;

endmodule
